// File: rtl/ldpc_3gpp_dec_buffer_ctrl_pkg.sv
// Shared types and defaults for the LDPC decoder input-buffer bank controller.
// Holds the frame code context, base-graph/lifting descriptor, bank index type,
// the bank-count default and the read FSM state encoding.
package ldpc_3gpp_dec_buffer_ctrl_pkg;

  localparam int cBUF_N_DEF  = 2;
  localparam int cBANK_W_DEF = 2;

  typedef logic [cBANK_W_DEF-1:0] bank_idx_t;

  // base graph select plus lifting-size set index and exponent
  typedef struct packed {
    logic       bg;
    logic [2:0] ils;
    logic [2:0] jzc;
  } hb_zc_t;

  // per-frame decode context carried alongside each bank
  typedef struct packed {
    hb_zc_t     hb_zc;
    logic [3:0] ncol;
    logic [4:0] tag;
  } code_ctx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RUN  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ldpc_3gpp_dec_buffer_ctrl_if.sv
// Engine-side handshake of the buffer controller: request/ack, bank, context, done.
// master = controller, slave = decoder engine.
// ostart is held until iack; orbank/ocode_ctx stay stable through the run.
interface ldpc_3gpp_dec_buffer_ctrl_if #(
  parameter int pBANK_W = 2
);
  import ldpc_3gpp_dec_buffer_ctrl_pkg::*;

  logic               ostart;
  logic               iack;
  logic [pBANK_W-1:0] orbank;
  code_ctx_t          ocode_ctx;
  logic               idone;

  modport master (output ostart, orbank, ocode_ctx, input iack, idone);
  modport slave  (input ostart, orbank, ocode_ctx, output iack, idone);

endinterface

// File: rtl/ldpc_3gpp_dec_buffer_ctrl.sv
// Bank controller for the multi-bank LLR input buffer: write/read pointers, occupancy flags, in-order hand-off.
// Latency: iwfull -> flags 1 cycle, iwfull -> ostart 2 cycles from empty; idone -> next ostart after 1 idle cycle.
// Backpressure: ofull/ofulla stall the source; a write while full is dropped and sets sticky oerr.
module ldpc_3gpp_dec_buffer_ctrl
  import ldpc_3gpp_dec_buffer_ctrl_pkg::*;
#(
  parameter int pBUF_N  = cBUF_N_DEF,
  parameter int pBANK_W = cBANK_W_DEF
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               iwfull,
  input  code_ctx_t          icode_ctx,
  output logic [pBANK_W-1:0] owbank,
  output logic               oempty,
  output logic               oemptya,
  output logic               ofull,
  output logic               ofulla,
  output logic               oerr,
  ldpc_3gpp_dec_buffer_ctrl_if.master eng
);

  localparam int                   cCNT_W    = $clog2(pBUF_N + 1);
  localparam logic [cCNT_W-1:0]    cFULL     = cCNT_W'(pBUF_N);
  localparam logic [cCNT_W-1:0]    cFULLA    = cCNT_W'(pBUF_N - 1);
  localparam logic [pBANK_W-1:0]   cPTR_LAST = pBANK_W'(pBUF_N - 1);

  logic [pBANK_W-1:0] wptr, rptr;
  logic [cCNT_W-1:0]  nfull, nfull_nxt;
  logic               rd, rd_nxt;
  logic [cCNT_W-1:0]  used, used_nxt;
  rd_state_t          state, state_nxt;
  code_ctx_t          ctx [pBUF_N];
  code_ctx_t          ctx_rd;
  logic               ostart_r;

  logic wr_acc, wr_ovf, claim, release_b;

  // occupancy bookkeeping; writes are judged against the pre-release count
  always_comb begin
    used      = nfull + cCNT_W'(rd);
    wr_acc    = iwfull && (used != cFULL);
    wr_ovf    = iwfull && (used == cFULL);
    claim     = (state == ST_REQ) && eng.iack;
    release_b = (state == ST_RUN) && eng.idone;

    nfull_nxt = nfull;
    case ({wr_acc, claim})
      2'b10:   nfull_nxt = nfull + cCNT_W'(1);
      2'b01:   nfull_nxt = nfull - cCNT_W'(1);
      default: nfull_nxt = nfull;
    endcase

    rd_nxt = rd;
    if (claim)
      rd_nxt = 1'b1;
    else if (release_b)
      rd_nxt = 1'b0;

    used_nxt = nfull_nxt + cCNT_W'(rd_nxt);
  end

  // read FSM next state: request a bank, wait for accept, wait for release
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (nfull != '0) state_nxt = ST_REQ;
      ST_REQ:  if (eng.iack)    state_nxt = ST_RUN;
      ST_RUN:  if (eng.idone)   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state, pointers, counters and registered flags
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state    <= ST_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      nfull    <= '0;
      rd       <= 1'b0;
      ostart_r <= 1'b0;
      oerr     <= 1'b0;
      oempty   <= 1'b1;
      oemptya  <= 1'b1;
      ofull    <= 1'b0;
      ofulla   <= 1'b0;
    end else if (iclkena) begin
      state    <= state_nxt;
      nfull    <= nfull_nxt;
      rd       <= rd_nxt;
      ostart_r <= (state_nxt == ST_REQ);
      if (wr_acc)
        wptr <= (wptr == cPTR_LAST) ? '0 : wptr + pBANK_W'(1);
      if (release_b)
        rptr <= (rptr == cPTR_LAST) ? '0 : rptr + pBANK_W'(1);
      if (wr_ovf)
        oerr <= 1'b1;
      oempty  <= (nfull_nxt == '0);
      oemptya <= (used_nxt == '0);
      ofull   <= (used_nxt == cFULL);
      ofulla  <= (used_nxt >= cFULLA);
    end
  end

  // context capture only on an accepted write, so a full or busy bank is never overwritten
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      for (int i = 0; i < pBUF_N; i++)
        ctx[i] <= '0;
    end else if (iclkena) begin
      for (int i = 0; i < pBUF_N; i++)
        if (wr_acc && (wptr == pBANK_W'(i)))
          ctx[i] <= icode_ctx;
    end
  end

  // context of the bank under request / being read
  always_comb begin
    ctx_rd = '0;
    for (int i = 0; i < pBUF_N; i++)
      if (rptr == pBANK_W'(i))
        ctx_rd = ctx[i];
  end

  assign owbank        = wptr;
  assign eng.ostart    = ostart_r;
  assign eng.orbank    = rptr;
  assign eng.ocode_ctx = ctx_rd;

endmodule

// File: tb/tb_ldpc_3gpp_dec_buffer_ctrl.sv
// Directed bench for the buffer bank controller: a 2-bank and a 3-bank instance
// driven with hand-computed expected values; one summary line at the end.
module tb_ldpc_3gpp_dec_buffer_ctrl;
  import ldpc_3gpp_dec_buffer_ctrl_pkg::*;

  logic iclk = 1'b0;
  logic ireset, iclkena;

  logic      iwfull2, iwfull3;
  code_ctx_t icode_ctx2, icode_ctx3;
  logic [1:0] owbank2, owbank3;
  logic oempty2, oemptya2, ofull2, ofulla2, oerr2;
  logic oempty3, oemptya3, ofull3, ofulla3, oerr3;

  ldpc_3gpp_dec_buffer_ctrl_if #(.pBANK_W(2)) eng2 ();
  ldpc_3gpp_dec_buffer_ctrl_if #(.pBANK_W(2)) eng3 ();

  int n_chk = 0;
  int n_err = 0;

  always #5 iclk = ~iclk;

  ldpc_3gpp_dec_buffer_ctrl #(.pBUF_N(2), .pBANK_W(2)) u_dut2 (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .iwfull(iwfull2), .icode_ctx(icode_ctx2), .owbank(owbank2),
    .oempty(oempty2), .oemptya(oemptya2), .ofull(ofull2), .ofulla(ofulla2),
    .oerr(oerr2), .eng(eng2)
  );

  ldpc_3gpp_dec_buffer_ctrl #(.pBUF_N(3), .pBANK_W(2)) u_dut3 (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .iwfull(iwfull3), .icode_ctx(icode_ctx3), .owbank(owbank3),
    .oempty(oempty3), .oemptya(oemptya3), .ofull(ofull3), .ofulla(ofulla3),
    .oerr(oerr3), .eng(eng3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic wait_start3(input string tag);
    int n = 0;
    while (eng3.ostart !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(eng3.ostart), 32'd1);
  endtask

  task automatic serve3(input string tag, input logic [1:0] bank, input code_ctx_t c);
    wait_start3({tag, "_start"});
    chk({tag, "_rbank"}, 32'(eng3.orbank), 32'(bank));
    chk({tag, "_ctx"}, 32'(eng3.ocode_ctx), 32'(c));
    eng3.iack = 1'b1; tick(); eng3.iack = 1'b0;
    eng3.idone = 1'b1; tick(); eng3.idone = 1'b0;
  endtask

  localparam code_ctx_t C0 = 16'hA5C3;
  localparam code_ctx_t C1 = 16'h1111;
  localparam code_ctx_t C2 = 16'h2222;
  localparam code_ctx_t C3 = 16'h3333;
  localparam code_ctx_t C4 = 16'h4444;
  localparam code_ctx_t D0 = 16'h0D00;
  localparam code_ctx_t D1 = 16'h0D11;
  localparam code_ctx_t D2 = 16'h0D22;
  localparam code_ctx_t D3 = 16'h0D33;

  initial begin
    ireset = 1'b1; iclkena = 1'b1;
    iwfull2 = 1'b0; iwfull3 = 1'b0; icode_ctx2 = '0; icode_ctx3 = '0;
    eng2.iack = 1'b0; eng2.idone = 1'b0; eng3.iack = 1'b0; eng3.idone = 1'b0;
    #23 ireset = 1'b0;
    tick();

    // reset state and 20 idle cycles
    chk("rst_rbank", 32'(eng2.orbank), 32'd0);
    chk("rst_ctx", 32'(eng2.ocode_ctx), 32'd0);
    chk("rst_err", 32'(oerr2), 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("idle_flags", 32'({oempty2, oemptya2, ofull2, ofulla2, eng2.ostart, owbank2}), 32'b1100000);
      tick();
    end

    // single frame through the 2-bank instance
    iwfull2 = 1'b1; icode_ctx2 = C0; tick(); iwfull2 = 1'b0;       // edge k
    chk("sf_wbank", 32'(owbank2), 32'd1);
    chk("sf_flags", 32'({oempty2, oemptya2, ofull2, ofulla2, eng2.ostart}), 32'b00010);
    tick();                                                         // k+1
    chk("sf_start", 32'(eng2.ostart), 32'd1);
    chk("sf_rbank", 32'(eng2.orbank), 32'd0);
    chk("sf_ctx", 32'(eng2.ocode_ctx), 32'(C0));
    tick();                                                         // k+2
    chk("sf_start_hold", 32'(eng2.ostart), 32'd1);
    eng2.iack = 1'b1; tick(); eng2.iack = 1'b0;                     // k+3
    chk("sf_ack_flags", 32'({oempty2, oemptya2, ofulla2, eng2.ostart}), 32'b1010);
    for (int i = 0; i < 6; i++) begin                               // k+4..k+9
      tick();
      chk("sf_run_stable", 32'({eng2.orbank, eng2.ocode_ctx}), 32'({2'd0, C0}));
    end
    eng2.idone = 1'b1; tick(); eng2.idone = 1'b0;                   // k+10
    chk("sf_done_flags", 32'({oempty2, oemptya2, ofull2, ofulla2}), 32'b1100);
    tick();
    chk("sf_no_restart", 32'(eng2.ostart), 32'd0);

    // fill with engine stalled, then overflow
    iwfull2 = 1'b1; icode_ctx2 = C1; tick();                        // bank 1
    icode_ctx2 = C2; tick(); iwfull2 = 1'b0;                        // bank 0
    chk("fill_flags", 32'({ofull2, ofulla2, oempty2}), 32'b110);
    chk("fill_wbank", 32'(owbank2), 32'd1);
    chk("fill_req", 32'({eng2.ostart, eng2.orbank, eng2.ocode_ctx}), 32'({1'b1, 2'd1, C1}));
    iwfull2 = 1'b1; icode_ctx2 = C3; tick(); iwfull2 = 1'b0;
    chk("ovf_err", 32'(oerr2), 32'd1);
    chk("ovf_wbank", 32'(owbank2), 32'd1);
    chk("ovf_ctx1", 32'(eng2.ocode_ctx), 32'(C1));
    chk("ovf_full", 32'(ofull2), 32'd1);

    // drain bank 1, then bank 0 must still hold C2
    eng2.iack = 1'b1; tick(); eng2.iack = 1'b0;
    eng2.idone = 1'b1; tick(); eng2.idone = 1'b0;
    chk("drain_flags", 32'({ofull2, ofulla2, oempty2}), 32'b010);
    tick();
    chk("ovf_ctx0", 32'({eng2.ostart, eng2.orbank, eng2.ocode_ctx}), 32'({1'b1, 2'd0, C2}));

    // iwfull with iack in REQ (nfull = 1): count unchanged, bank claimed, write accepted
    iwfull2 = 1'b1; icode_ctx2 = C4; eng2.iack = 1'b1; tick();
    iwfull2 = 1'b0; eng2.iack = 1'b0;
    chk("sim_ack_flags", 32'({oempty2, ofull2, eng2.ostart}), 32'b010);
    chk("sim_ack_wbank", 32'(owbank2), 32'd0);

    // iwfull with idone while full: still an overflow, write dropped
    iwfull2 = 1'b1; icode_ctx2 = C3; eng2.idone = 1'b1; tick();
    iwfull2 = 1'b0; eng2.idone = 1'b0;
    chk("sim_done_wbank", 32'(owbank2), 32'd0);
    chk("sim_done_flags", 32'({ofull2, ofulla2, oempty2}), 32'b010);
    tick();
    chk("sim_done_req", 32'({eng2.ostart, eng2.orbank, eng2.ocode_ctx}), 32'({1'b1, 2'd1, C4}));

    // clock enable low freezes everything, pulses are lost
    iclkena = 1'b0; eng2.iack = 1'b1; iwfull2 = 1'b1;
    tick(); tick(); tick();
    eng2.iack = 1'b0; iwfull2 = 1'b0;
    chk("ena_hold", 32'({eng2.ostart, eng2.orbank, owbank2}), 32'({1'b1, 2'd1, 2'd0}));
    iclkena = 1'b1; tick();
    chk("ena_resume", 32'(eng2.ostart), 32'd1);

    // asynchronous reset while running
    eng2.iack = 1'b1; tick(); eng2.iack = 1'b0;
    chk("run_start_low", 32'(eng2.ostart), 32'd0);
    #2 ireset = 1'b1;
    #1;
    chk("arst_flags", 32'({oempty2, oemptya2, ofull2, ofulla2, eng2.ostart, oerr2}), 32'b110000);
    chk("arst_banks", 32'({owbank2, eng2.orbank, eng2.ocode_ctx}), 32'd0);
    tick();
    ireset = 1'b0;
    tick();

    // 3-bank ordering and wrap
    iwfull3 = 1'b1; icode_ctx3 = D0; tick();
    icode_ctx3 = D1; tick();
    icode_ctx3 = D2; tick(); iwfull3 = 1'b0;
    chk("ord_full", 32'({ofull3, ofulla3, owbank3}), 32'({1'b1, 1'b1, 2'd0}));
    serve3("ord0", 2'd0, D0);
    iwfull3 = 1'b1; icode_ctx3 = D3; tick(); iwfull3 = 1'b0;
    chk("ord_wrap_wbank", 32'(owbank3), 32'd1);
    serve3("ord1", 2'd1, D1);
    serve3("ord2", 2'd2, D2);
    serve3("ord3", 2'd0, D3);
    chk("ord_end", 32'({oempty3, oemptya3, ofull3, ofulla3, oerr3}), 32'b11000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
